// File: rtl/frac_baud_generator.sv
// Fractional baud-rate generator: an oversample tick from a runtime integer+fraction divisor,
// plus bit-rate and mid-bit enables derived from the oversample count.
module frac_baud_generator #(
  parameter int unsigned DIV_INT_WIDTH  = 16,
  parameter int unsigned DIV_FRAC_WIDTH = 4,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned RST_DIV_INT    = 325,
  parameter int unsigned RST_DIV_FRAC   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [DIV_INT_WIDTH-1:0]  div_int_i,
  input  logic [DIV_FRAC_WIDTH-1:0] div_frac_i,
  input  logic                      div_load_i,
  input  logic                      resync_i,
  output logic                      div_pending_o,
  output logic                      sample_en_o,
  output logic                      bit_en_o,
  output logic                      mid_bit_en_o
);

  // One extra bit so the period target D + extra never overflows.
  localparam int unsigned CntW = DIV_INT_WIDTH + 1;
  localparam int unsigned OsW  = $clog2(OVERSAMPLE);

  localparam logic [OsW-1:0]            OsLast  = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0]            OsMid   = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_INT_WIDTH-1:0]  RstInt  = DIV_INT_WIDTH'(RST_DIV_INT);
  localparam logic [DIV_FRAC_WIDTH-1:0] RstFrac = DIV_FRAC_WIDTH'(RST_DIV_FRAC);

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [OsW-1:0]            os_q, os_d;
  logic [DIV_FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                      extra_q, extra_d;
  logic [DIV_INT_WIDTH-1:0]  act_int_q, act_int_d;
  logic [DIV_FRAC_WIDTH-1:0] act_frac_q, act_frac_d;
  logic [DIV_INT_WIDTH-1:0]  pend_int_q, pend_int_d;
  logic [DIV_FRAC_WIDTH-1:0] pend_frac_q, pend_frac_d;
  logic                      pend_q, pend_d;
  logic                      sample_q, sample_d;
  logic                      bit_q, bit_d;
  logic                      mid_q, mid_d;

  logic [CntW-1:0]           div_eff;
  logic [CntW-1:0]           tgt_m1;
  logic                      tick;
  logic [DIV_FRAC_WIDTH:0]   acc_sum;
  logic [DIV_INT_WIDTH-1:0]  new_int;
  logic [DIV_FRAC_WIDTH-1:0] new_frac;
  logic                      have_new;

  // Period target, tick detect and the divisor that would be applied at a boundary.
  always_comb begin
    div_eff  = (act_int_q < DIV_INT_WIDTH'(2)) ? CntW'(2) : {1'b0, act_int_q};
    tgt_m1   = div_eff + CntW'(extra_q) - CntW'(1);
    tick     = enable_i && (cnt_q == tgt_m1);
    acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
    // A load in the boundary cycle itself takes precedence over an older pending value.
    new_int  = div_load_i ? div_int_i : pend_int_q;
    new_frac = div_load_i ? div_frac_i : pend_frac_q;
    have_new = div_load_i | pend_q;
  end

  // Next-state: resync beats tick; disable freezes the counters.
  always_comb begin
    cnt_d       = cnt_q;
    os_d        = os_q;
    acc_d       = acc_q;
    extra_d     = extra_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    sample_d    = 1'b0;
    bit_d       = 1'b0;
    mid_d       = 1'b0;

    if (resync_i) begin
      cnt_d   = '0;
      os_d    = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      if (have_new) begin
        act_int_d  = new_int;
        act_frac_d = new_frac;
        pend_d     = 1'b0;
      end
    end else if (!enable_i) begin
      // Nothing is running, so a load can go live straight away.
      if (div_load_i) begin
        act_int_d  = div_int_i;
        act_frac_d = div_frac_i;
        pend_d     = 1'b0;
      end
    end else if (tick) begin
      cnt_d    = '0;
      sample_d = 1'b1;
      acc_d    = acc_sum[DIV_FRAC_WIDTH-1:0];
      extra_d  = acc_sum[DIV_FRAC_WIDTH];
      os_d     = (os_q == OsLast) ? '0 : os_q + OsW'(1);
      bit_d    = (os_q == OsLast);
      mid_d    = (os_q == OsMid);
      if (have_new) begin
        act_int_d  = new_int;
        act_frac_d = new_frac;
        pend_d     = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
      if (div_load_i) begin
        pend_int_d  = div_int_i;
        pend_frac_d = div_frac_i;
        pend_d      = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      os_q        <= '0;
      acc_q       <= '0;
      extra_q     <= 1'b0;
      act_int_q   <= RstInt;
      act_frac_q  <= RstFrac;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      sample_q    <= 1'b0;
      bit_q       <= 1'b0;
      mid_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      os_q        <= os_d;
      acc_q       <= acc_d;
      extra_q     <= extra_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      sample_q    <= sample_d;
      bit_q       <= bit_d;
      mid_q       <= mid_d;
    end
  end

  assign div_pending_o = pend_q;
  assign sample_en_o   = sample_q;
  assign bit_en_o      = bit_q;
  assign mid_bit_en_o  = mid_q;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Directed bench for frac_baud_generator: table of divisor settings plus corner sequences.
module tb_frac_baud_generator;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] div_int_i = '0;
  logic [3:0]  div_frac_i = '0;
  logic        div_load_i = 1'b0;
  logic        resync_i = 1'b0;
  logic        div_pending_o, sample_en_o, bit_en_o, mid_bit_en_o;

  int errors = 0;
  int checks = 0;
  int tick_cnt, first_mid, first_bit, misalign;

  frac_baud_generator dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .div_int_i    (div_int_i),
    .div_frac_i   (div_frac_i),
    .div_load_i   (div_load_i),
    .resync_i     (resync_i),
    .div_pending_o(div_pending_o),
    .sample_en_o  (sample_en_o),
    .bit_en_o     (bit_en_o),
    .mid_bit_en_o (mid_bit_en_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int di;
    int df;
    int g1;
    int g2;
    int g3;
    int sum32;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts negedges until the next sample pulse, recording bit/mid tick positions.
  task automatic wait_pulse(output int gap);
    bit got;
    got = 1'b0;
    gap = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      gap++;
      if ((bit_en_o || mid_bit_en_o) && !sample_en_o) misalign++;
      if (sample_en_o) begin
        tick_cnt++;
        if (mid_bit_en_o && first_mid == 0) first_mid = tick_cnt;
        if (bit_en_o && first_bit == 0) first_bit = tick_cnt;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no sample_en_o pulse within 2000 cycles");
    end
  endtask

  task automatic clear_track();
    tick_cnt  = 0;
    first_mid = 0;
    first_bit = 0;
    misalign  = 0;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    enable_i   = 1'b0;
    div_load_i = 1'b0;
    resync_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic load_disabled(input int di, input int df);
    div_int_i  = 16'(di);
    div_frac_i = 4'(df);
    div_load_i = 1'b1;
    @(negedge clk);
    div_load_i = 1'b0;
    check("pending_after_disabled_load", int'(div_pending_o), 0);
  endtask

  task automatic idle_cycles(input int n, input string name, inout int cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt++;
      check(name, int'(sample_en_o), 0);
    end
  endtask

  initial begin
    int g, g2, g3, sum, cnt;

    vecs[0] = '{di: 4, df: 0,  g1: 4, g2: 4, g3: 4, sum32: 128};
    vecs[1] = '{di: 4, df: 8,  g1: 4, g2: 4, g3: 5, sum32: 144};
    vecs[2] = '{di: 0, df: 0,  g1: 2, g2: 2, g3: 2, sum32: 64};
    vecs[3] = '{di: 1, df: 0,  g1: 2, g2: 2, g3: 2, sum32: 64};
    vecs[4] = '{di: 3, df: 4,  g1: 3, g2: 3, g3: 3, sum32: 104};
    vecs[5] = '{di: 5, df: 15, g1: 5, g2: 5, g3: 6, sum32: 190};

    // Reset state.
    do_reset();
    @(negedge clk);
    check("reset_sample", int'(sample_en_o), 0);
    check("reset_bit", int'(bit_en_o), 0);
    check("reset_mid", int'(mid_bit_en_o), 0);
    check("reset_pending", int'(div_pending_o), 0);

    // Table: spacing, fractional average, and bit/mid positions per divisor.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_disabled(vecs[v].di, vecs[v].df);
      enable_i = 1'b1;
      clear_track();
      wait_pulse(g);
      check($sformatf("v%0d_gap1", v), g, vecs[v].g1);
      wait_pulse(g2);
      check($sformatf("v%0d_gap2", v), g2, vecs[v].g2);
      wait_pulse(g3);
      check($sformatf("v%0d_gap3", v), g3, vecs[v].g3);
      sum = g2 + g3;
      for (int k = 0; k < 30; k++) begin
        wait_pulse(g);
        sum += g;
      end
      check($sformatf("v%0d_sum32", v), sum, vecs[v].sum32);
      check($sformatf("v%0d_first_mid_tick", v), first_mid, 8);
      check($sformatf("v%0d_first_bit_tick", v), first_bit, 16);
      check($sformatf("v%0d_misaligned", v), misalign, 0);
    end

    // Load mid-period: current period keeps 10, then 6.
    do_reset();
    load_disabled(10, 0);
    enable_i = 1'b1;
    clear_track();
    wait_pulse(g);
    check("load_first_gap", g, 10);
    cnt = 0;
    idle_cycles(3, "load_no_early", cnt);
    div_int_i  = 16'd6;
    div_frac_i = 4'd0;
    div_load_i = 1'b1;
    @(negedge clk);
    cnt++;
    div_load_i = 1'b0;
    check("load_pending_set", int'(div_pending_o), 1);
    check("load_no_runt", int'(sample_en_o), 0);
    wait_pulse(g);
    check("load_old_period", cnt + g, 10);
    check("load_pending_clear", int'(div_pending_o), 0);
    wait_pulse(g);
    check("load_new_period1", g, 6);
    wait_pulse(g);
    check("load_new_period2", g, 6);

    // Enable low 7 cycles mid-period.
    cnt = 0;
    idle_cycles(2, "pause_pre", cnt);
    enable_i = 1'b0;
    idle_cycles(7, "pause_quiet", cnt);
    enable_i = 1'b1;
    wait_pulse(g);
    check("pause_total_gap", cnt + g, 13);
    wait_pulse(g);
    check("pause_after_gap", g, 6);

    // Resync at os_r=9, on the cycle a tick would have fired.
    do_reset();
    load_disabled(4, 0);
    enable_i = 1'b1;
    clear_track();
    for (int k = 0; k < 9; k++) wait_pulse(g);
    cnt = 0;
    idle_cycles(3, "resync_pre", cnt);
    resync_i = 1'b1;
    @(negedge clk);
    resync_i = 1'b0;
    check("resync_suppressed", int'(sample_en_o), 0);
    clear_track();
    wait_pulse(g);
    check("resync_first_gap", g, 4);
    for (int k = 0; k < 15; k++) wait_pulse(g);
    check("resync_first_mid_tick", first_mid, 8);
    check("resync_first_bit_tick", first_bit, 16);
    check("resync_misaligned", misalign, 0);

    // Reset mid-period with a pending load: divisor returns to 325.
    wait_pulse(g);
    @(negedge clk);
    div_int_i  = 16'd7;
    div_frac_i = 4'd0;
    div_load_i = 1'b1;
    @(negedge clk);
    div_load_i = 1'b0;
    check("rst_pending_before", int'(div_pending_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_sample", int'(sample_en_o), 0);
    check("rst_bit", int'(bit_en_o), 0);
    check("rst_mid", int'(mid_bit_en_o), 0);
    check("rst_pending", int'(div_pending_o), 0);
    wait_pulse(g);
    check("rst_default_div", g, 325);
    check("rst_pending_after", int'(div_pending_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frac_baud_generator.md
Name: frac_baud_generator

Overview:
Parametrised successor to the fixed-table UART baud generator. It produces a one-cycle oversample enable from a runtime-programmable divisor with an integer and a fractional part, so any baud rate can be reached from any clock with low average error. It also derives a bit-rate enable and a mid-bit enable from a configurable oversample ratio. Sits between the UART control/CSR logic and the Rx/Tx engines; a resync input lets Rx realign phase on a start-bit edge.

Parameters:
DIV_INT_WIDTH, 16, width of integer divisor (clock cycles per oversample tick)
DIV_FRAC_WIDTH, 4, width of fractional divisor; fraction = div_frac / 2^DIV_FRAC_WIDTH
OVERSAMPLE, 16, oversample ticks per bit, legal range 2..256
RST_DIV_INT, 325, active integer divisor after reset
RST_DIV_FRAC, 0, active fractional divisor after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  active-high synchronous reset
enable_i  in  1  run enable; low freezes counters
div_int_i  in  DIV_INT_WIDTH  requested integer divisor
div_frac_i  in  DIV_FRAC_WIDTH  requested fractional divisor
div_load_i  in  1  one-cycle strobe; captures div_int_i/div_frac_i as pending
resync_i  in  1  restart tick and bit phase
div_pending_o  out  1  loaded divisor not yet active
sample_en_o  out  1  oversample enable, one-cycle pulse
bit_en_o  out  1  bit-rate enable, one-cycle pulse
mid_bit_en_o  out  1  mid-bit enable, one-cycle pulse

Behaviour:
- One clock, synchronous active-high reset. Reset: cycle counter 0, oversample counter 0, frac accumulator 0, extra_r 0, active divisor = RST_DIV_INT/RST_DIV_FRAC, div_pending_o 0, all enables 0.
- All outputs registered.
- Effective integer divisor D = max(active div_int, 2); values 0/1 clamp to 2.
- Period target T = D + extra_r.
- While enable_i=1, each cycle:
  - If cnt_r == T-1: cnt_r <= 0; sample_en_o <= 1; {carry, acc} <= acc + active div_frac (DIV_FRAC_WIDTH+1 bits); extra_r <= carry.
  - Otherwise: cnt_r++ and sample_en_o <= 0.
  - Average period = D + div_frac/2^DIV_FRAC_WIDTH cycles. First period after reset/resync is exactly D.
- Oversample counter os_r advances only on tick cycles (cnt_r == T-1), range 0..OVERSAMPLE-1 with wrap.
  - bit_en_o <= 1 on a tick where os_r == OVERSAMPLE-1.
  - mid_bit_en_o <= 1 on a tick where os_r == OVERSAMPLE/2 - 1 (integer division).
  - Both pulses coincide with sample_en_o.
- enable_i=0: cnt_r, os_r, acc, extra_r hold; all enables 0 next cycle. Resuming continues from held state.
- div_load_i: latch inputs into pending regs and set div_pending_o (next cycle). Pending value becomes active at the next tick boundary (cnt_r == T-1 with enable_i=1) and div_pending_o clears the cycle after. The tick's accumulator update uses the old frac; the new divisor governs the following period. Load on the boundary cycle itself is applied at that same boundary.
- Load while already pending: latest value overwrites; only the last is applied.
- Load while enable_i=0: applied immediately (next cycle active; div_pending_o stays 0).
- resync_i=1 (priority over tick; below rst_i): cnt_r, os_r, acc, extra_r <= 0. Enables forced 0 that cycle. Pending divisor is applied at the same time.
- Pending/active registers are never changed by enable_i.

Test Plan:
- Reset, enable_i=1, load div 4.0 while disabled then enable -> sample_en_o every 4 cycles, bit_en_o every 64 cycles, mid_bit_en_o 32 cycles before each bit_en_o.
- div_int=4, div_frac=8 (0.5) -> tick spacings 4,4,5,4,5,…; any 32 consecutive periods after the first sum to 144 cycles.
- Running at div 10, pulse div_load_i with 6 mid-period -> div_pending_o=1 until boundary; current period stays 10, next periods 6, no runt pulse.
- div_int=0 and 1 -> tick every 2 cycles; enable_i low for 7 cycles mid-period -> no pulses, spacing resumes with total gap = remaining count + 7.
- resync_i asserted at os_r=9 -> no pulse that cycle; next sample_en_o after D cycles; first mid_bit_en_o on 8th tick, first bit_en_o on 16th tick.
- rst_i asserted mid-period with pending load -> all outputs 0 next cycle; divisor back to 325.0; pending discarded.
